clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of the divide value and the internal counter.
REQ-002 Parameter DEFAULT_DIV, default 2: half-period count loaded into active_div at reset; SHALL be 1..2^CNT_W-1.
REQ-003 clk_in  input  1: the single clock; all logic on posedge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 en  input  1: run request; 1 = generate clk_out, 0 = stop cleanly.
REQ-006 cfg_valid  input  1: new divide value offered.
REQ-007 cfg_div  input  CNT_W: requested half-period count N, giving clk_out period 2N clk_in cycles.
REQ-008 cfg_ready  output  1: controller can accept cfg_div this cycle.
REQ-009 cfg_err  output  1: one-cycle pulse when an accepted cfg_div is 0.
REQ-010 clk_out  output  1: registered divided clock.
REQ-011 edge_tick  output  1: one-cycle pulse in every cycle in which clk_out changes value.
REQ-012 active_div  output  CNT_W: divide value currently in force.
REQ-013 busy  output  1: high in RUN, PEND and STOPPING.

Function
REQ-014 States: IDLE, RUN, PEND (new value held, waiting for a boundary), STOPPING (finishing the high half before halting).
REQ-015 Handshake: transfer occurs on a posedge where cfg_valid=1 and cfg_ready=1; cfg_ready=1 in IDLE and RUN, 0 in PEND and STOPPING.
REQ-016 Transfer with cfg_div=0: cfg_err=1 on the next cycle only; value discarded; state, counter and active_div unchanged.
REQ-017 Valid transfer in IDLE: active_div takes cfg_div on that edge; state stays IDLE.
REQ-018 Valid transfer in RUN: value goes to a pending register; state goes to PEND; active_div unchanged.
REQ-019 IDLE: counter=0, clk_out=0; en=1 sampled -> RUN with counter=0.
REQ-020 RUN/PEND counting: if counter==active_div-1, then counter<=0, clk_out toggles and edge_tick=1; otherwise counter<=counter+1.
REQ-021 First clk_out rise occurs exactly active_div posedges after the edge that sampled en=1 in IDLE.
REQ-022 PEND boundary: on the toggle edge of REQ-020, active_div<=pending and state->RUN; the next half-period uses the new value. The change therefore occurs only at a half-period boundary, never mid-half.
REQ-023 en=0 sampled in RUN/PEND with clk_out=0: state->IDLE and counter<=0 on that edge; any pending value is copied into active_div; no edge_tick.
REQ-024 en=0 sampled in RUN/PEND with clk_out=1: state->STOPPING; counting continues with the old active_div; at counter==active_div-1, clk_out<=0, edge_tick=1, pending (if any) is applied, and state->IDLE.
REQ-025 en is ignored while in STOPPING; restart requires en=1 sampled in IDLE.
REQ-026 Same-edge en=0 and valid transfer in RUN: the value is stored as pending and the en=0 handling (REQ-023/024) applies.
REQ-027 active_div=1: clk_out toggles every cycle, giving clk_in/2.
REQ-028 The counter SHALL never exceed active_div-1. Overflow at 2^CNT_W is impossible.

Reset
REQ-029 rst_n=0 immediately forces IDLE, counter=0, clk_out=0, edge_tick=0, cfg_err=0, busy=0, cfg_ready=1, active_div=DEFAULT_DIV, and clears the pending value, regardless of state (including mid-PEND or STOPPING).
REQ-030 After rst_n deasserts, the first edge may sample en and cfg_valid normally.

Verification
REQ-031 Reset, en=1 held, DEFAULT_DIV=2 -> clk_out rises 2 edges after en sampled, then period 4 clk_in, 50% duty, edge_tick on each change.
REQ-032 Running N=3, offer cfg_div=5 mid low-half -> cfg_ready drops one cycle later; the current half stays 3 cycles; subsequent halves are 5; active_div=5 from the boundary edge.
REQ-033 cfg_div=0 in RUN -> handshake completes, single cfg_err pulse, period unchanged, state stays RUN.
REQ-034 N=4, en=0 at the second cycle of the high half -> clk_out stays high 2 more cycles, falls with edge_tick, busy=0; en=1 during STOPPING is ignored.
REQ-035 N=1 -> clk_out toggles every cycle and edge_tick is constantly 1; en=0 while clk_out=0 -> immediate IDLE.
REQ-036 rst_n pulsed low in PEND -> all outputs at reset values asynchronously, active_div=DEFAULT_DIV, pending value lost.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock divider with glitch-free control.
// clk_out is a registered clock whose half-period is active_div clk_in cycles.
// A new divide value is accepted through a valid/ready handshake. While running,
// the value is held pending and only takes effect at a half-period boundary.
// Stopping always completes a high half, so clk_out never produces a runt pulse.

module clk_div_ctrl #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             edge_tick,
    output logic [CNT_W-1:0] active_div,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPend,
        StStopping
    } state_e;

    localparam logic [CNT_W-1:0] CntOne     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntZero    = '0;
    localparam logic [CNT_W-1:0] DivDefault = CNT_W'(DEFAULT_DIV);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             edge_tick_q, edge_tick_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0] active_div_q, active_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;

    logic             xfer;
    logic             xfer_ok;
    logic             run_xfer;
    logic             terminal;
    logic [CNT_W-1:0] div_m1;
    logic             pend_avail;
    logic [CNT_W-1:0] pend_val;

    // Handshake decode and half-period boundary detect.
    always_comb begin
        xfer     = cfg_valid & cfg_ready;
        xfer_ok  = xfer & (cfg_div != CntZero);
        run_xfer = xfer_ok & (state_q == StRun);
        // active_div is never 0, so div_m1 cannot wrap.
        div_m1   = active_div_q - CntOne;
        terminal = (cnt_q == div_m1);
        // Pending value as seen after this edge's handshake, for same-edge stop.
        pend_avail = pend_vld_q | run_xfer;
        pend_val   = run_xfer ? cfg_div : pend_div_q;
    end

    // Next-state and datapath update for all four states.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clk_out_d    = clk_out_q;
        edge_tick_d  = 1'b0;
        cfg_err_d    = xfer & (cfg_div == CntZero);
        active_div_d = active_div_q;
        pend_div_d   = pend_div_q;
        pend_vld_d   = pend_vld_q;

        unique case (state_q)
            StIdle: begin
                cnt_d     = CntZero;
                clk_out_d = 1'b0;
                if (xfer_ok) begin
                    active_div_d = cfg_div;
                end
                if (en) begin
                    state_d = StRun;
                end
            end

            StRun, StPend: begin
                if (run_xfer) begin
                    pend_div_d = cfg_div;
                    pend_vld_d = 1'b1;
                    state_d    = StPend;
                end
                if (!en) begin
                    if (!clk_out_q) begin
                        // Low half: halt at once, no edge produced.
                        state_d = StIdle;
                        cnt_d   = CntZero;
                        if (pend_avail) begin
                            active_div_d = pend_val;
                            pend_vld_d   = 1'b0;
                        end
                    end else if (terminal) begin
                        // High half ends on this very edge: fall and halt.
                        state_d     = StIdle;
                        cnt_d       = CntZero;
                        clk_out_d   = 1'b0;
                        edge_tick_d = 1'b1;
                        if (pend_avail) begin
                            active_div_d = pend_val;
                            pend_vld_d   = 1'b0;
                        end
                    end else begin
                        state_d = StStopping;
                        cnt_d   = cnt_q + CntOne;
                    end
                end else if (terminal) begin
                    cnt_d       = CntZero;
                    clk_out_d   = ~clk_out_q;
                    edge_tick_d = 1'b1;
                    if (state_q == StPend) begin
                        active_div_d = pend_div_q;
                        pend_vld_d   = 1'b0;
                        state_d      = StRun;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StStopping: begin
                // en is ignored here; finish the high half with the old divide value.
                if (terminal) begin
                    state_d     = StIdle;
                    cnt_d       = CntZero;
                    clk_out_d   = 1'b0;
                    edge_tick_d = 1'b1;
                    if (pend_vld_q) begin
                        active_div_d = pend_div_q;
                        pend_vld_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= CntZero;
            clk_out_q    <= 1'b0;
            edge_tick_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
            active_div_q <= DivDefault;
            pend_div_q   <= CntZero;
            pend_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clk_out_q    <= clk_out_d;
            edge_tick_q  <= edge_tick_d;
            cfg_err_q    <= cfg_err_d;
            active_div_q <= active_div_d;
            pend_div_q   <= pend_div_d;
            pend_vld_q   <= pend_vld_d;
        end
    end

    // Outputs: registered values plus state-decoded handshake/status.
    always_comb begin
        clk_out    = clk_out_q;
        edge_tick  = edge_tick_q;
        cfg_err    = cfg_err_q;
        active_div = active_div_q;
        cfg_ready  = (state_q == StIdle) || (state_q == StRun);
        busy       = (state_q != StIdle);
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed bench for clk_div_ctrl with an edge scoreboard.
// Expected clk_out edges (cycle number and new level) are queued when stimulus
// is applied and consumed as the DUT produces them.

module tb_clk_div_ctrl;

    localparam int unsigned CNT_W = 8;

    logic             clk_in;
    logic             rst_n;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             edge_tick;
    logic [CNT_W-1:0] active_div;
    logic             busy;

    typedef struct {
        int   cyc;
        logic lvl;
    } exp_edge_t;

    exp_edge_t sb[$];
    int        cyc;
    int        checks;
    int        errors;
    logic      prev_clk;
    int        c;

    clk_div_ctrl #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(2)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .edge_tick (edge_tick),
        .active_div(active_div),
        .busy      (busy)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Queue k edges of a run started by en=1 sampled at edge start+1, half-period n.
    task automatic push_run(input int start, input int n, input int k);
        exp_edge_t e;
        for (int i = 0; i < k; i++) begin
            e.cyc = start + 1 + n * (i + 1);
            e.lvl = (i % 2 == 0);
            sb.push_back(e);
        end
    endtask

    task automatic push_edge(input int at, input logic lvl);
        exp_edge_t e;
        e.cyc = at;
        e.lvl = lvl;
        sb.push_back(e);
    endtask

    // One clock: sample 1ns after posedge and score any clk_out edge.
    task automatic tick();
        exp_edge_t e;
        @(posedge clk_in);
        #1;
        cyc++;
        if (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("edge_tick", 32'(edge_tick), 32'(1));
            chk("edge_level", 32'(clk_out), 32'(e.lvl));
        end else begin
            chk("no_edge", 32'(edge_tick), 32'(0));
            chk("clk_hold", 32'(clk_out), 32'(prev_clk));
        end
        prev_clk = clk_out;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_clk_out", 32'(clk_out), 32'(0));
        chk("rst_edge_tick", 32'(edge_tick), 32'(0));
        chk("rst_cfg_err", 32'(cfg_err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_cfg_ready", 32'(cfg_ready), 32'(1));
        chk("rst_active_div", 32'(active_div), 32'(2));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        prev_clk  = 1'b0;
        rst_n     = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;

        // Reset values.
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Default divide 2: first rise 2 edges after en is sampled, period 4.
        c  = cyc;
        en = 1'b1;
        push_run(c, 2, 4);
        tick();
        chk("run_busy", 32'(busy), 32'(1));
        repeat (8) tick();
        en = 1'b0;
        tick();
        chk("stop_low_busy", 32'(busy), 32'(0));

        // Program 3 in IDLE, run, then offer 5 mid low half.
        cfg_valid = 1'b1;
        cfg_div   = 8'd3;
        chk("idle_ready", 32'(cfg_ready), 32'(1));
        tick();
        cfg_valid = 1'b0;
        chk("idle_load", 32'(active_div), 32'(3));
        chk("idle_no_err", 32'(cfg_err), 32'(0));
        c  = cyc;
        en = 1'b1;
        push_run(c, 3, 3);
        push_edge(c + 15, 1'b0);
        push_edge(c + 20, 1'b1);
        repeat (7) tick();
        cfg_valid = 1'b1;
        cfg_div   = 8'd5;
        tick();
        cfg_valid = 1'b0;
        chk("pend_ready_low", 32'(cfg_ready), 32'(0));
        chk("pend_busy", 32'(busy), 32'(1));
        tick();
        chk("pend_div_held", 32'(active_div), 32'(3));
        tick();
        chk("boundary_div", 32'(active_div), 32'(5));
        chk("boundary_ready", 32'(cfg_ready), 32'(1));

        // Zero divide while running: single error pulse, nothing else changes.
        repeat (11) tick();
        cfg_valid = 1'b1;
        cfg_div   = 8'd0;
        tick();
        cfg_valid = 1'b0;
        chk("zero_err", 32'(cfg_err), 32'(1));
        chk("zero_ready", 32'(cfg_ready), 32'(1));
        tick();
        chk("zero_err_once", 32'(cfg_err), 32'(0));
        chk("zero_div_kept", 32'(active_div), 32'(5));
        push_edge(c + 25, 1'b0);
        tick();
        tick();

        // Offer 4 in the low half, then stop: pending value copied on halt.
        cfg_valid = 1'b1;
        cfg_div   = 8'd4;
        tick();
        cfg_valid = 1'b0;
        chk("pend2_ready", 32'(cfg_ready), 32'(0));
        en = 1'b0;
        tick();
        chk("halt_pend_copy", 32'(active_div), 32'(4));
        chk("halt_busy", 32'(busy), 32'(0));
        chk("halt_ready", 32'(cfg_ready), 32'(1));

        // Divide 4, en dropped in second cycle of the high half.
        c  = cyc;
        en = 1'b1;
        push_run(c, 4, 4);
        repeat (14) tick();
        en = 1'b0;
        tick();
        chk("stopping_busy", 32'(busy), 32'(1));
        chk("stopping_high", 32'(clk_out), 32'(1));
        en = 1'b1;
        tick();
        chk("stopping_ignore_en", 32'(busy), 32'(1));
        tick();
        chk("stopped_busy", 32'(busy), 32'(0));
        en = 1'b0;
        tick();
        chk("stopped_idle", 32'(busy), 32'(0));

        // Divide 1: toggles every cycle, stop with clk_out low halts at once.
        cfg_valid = 1'b1;
        cfg_div   = 8'd1;
        tick();
        cfg_valid = 1'b0;
        chk("div1_load", 32'(active_div), 32'(1));
        c  = cyc;
        en = 1'b1;
        push_run(c, 1, 6);
        repeat (7) tick();
        en = 1'b0;
        tick();
        chk("div1_halt_busy", 32'(busy), 32'(0));
        chk("div1_halt_low", 32'(clk_out), 32'(0));

        // Reset asserted mid-PEND: everything back to defaults, pending lost.
        cfg_valid = 1'b1;
        cfg_div   = 8'd3;
        tick();
        cfg_valid = 1'b0;
        c  = cyc;
        en = 1'b1;
        push_edge(c + 4, 1'b1);
        repeat (4) tick();
        cfg_valid = 1'b1;
        cfg_div   = 8'd7;
        tick();
        cfg_valid = 1'b0;
        chk("pend3_ready", 32'(cfg_ready), 32'(0));
        tick();
        chk("pre_rst_high", 32'(clk_out), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        chk("rst_sb_drained", 32'(sb.size()), 32'(0));
        en       = 1'b0;
        prev_clk = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        c  = cyc;
        en = 1'b1;
        push_run(c, 2, 3);
        repeat (7) tick();
        chk("post_rst_div", 32'(active_div), 32'(2));
        chk("post_rst_busy", 32'(busy), 32'(1));
        en = 1'b0;
        push_edge(c + 9, 1'b0);
        tick();
        tick();
        chk("final_busy", 32'(busy), 32'(0));
        chk("final_sb_empty", 32'(sb.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
